// File: rtl/dadda_mac_acc.sv
// Accumulate stage behind the 4x4 Dadda multiplier: sums LEN products per group
// and hands the sum and a per-group overflow flag downstream over valid/ready.
module dadda_mac_acc #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN    = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;

    // One extra bit on top of the accumulator captures the carry-out.
    logic [ACC_W:0]     sum_ext;
    logic               carry;

    assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign carry   = sum_ext[ACC_W];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        // Clear drops any pending result but leaves the last sum visible.
        if (sclr) begin
            state_d     = ST_ACC;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_acc_d   = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        if (cnt_q == LAST_CNT) begin
                            out_sum_d   = sum_ext[ACC_W-1:0];
                            out_ovf_d   = ovf_acc_q | carry;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            ovf_acc_d   = 1'b0;
                            state_d     = ST_HOLD;
                        end else begin
                            acc_d     = sum_ext[ACC_W-1:0];
                            ovf_acc_d = ovf_acc_q | carry;
                            cnt_d     = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (cnt_q != '0) || out_valid_q;

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Directed bench for dadda_mac_acc: main instance (ACC_W=16, LEN=4), a narrow
// ACC_W=9 instance for overflow, and a LEN=1 instance.
module tb_dadda_mac_acc;

    logic        clk;
    logic        rst_n;
    logic        sclr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_prod;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic        busy;

    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_ovf, n_busy;
    logic [7:0]  n_in_prod;
    logic [8:0]  n_out_sum;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ovf, s_busy;
    logic [7:0]  s_in_prod;
    logic [15:0] s_out_sum;

    int checks;
    int errors;

    dadda_mac_acc #(.PROD_W(8), .ACC_W(16), .LEN(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sclr(sclr),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
    );

    dadda_mac_acc #(.PROD_W(8), .ACC_W(9), .LEN(4), .CNT_W(8)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .sclr(1'b0),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_prod(n_in_prod),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_sum(n_out_sum), .out_ovf(n_out_ovf), .busy(n_busy)
    );

    dadda_mac_acc #(.PROD_W(8), .ACC_W(16), .LEN(1), .CNT_W(8)) dut_single (
        .clk(clk), .rst_n(rst_n), .sclr(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_prod(s_in_prod),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .out_sum(s_out_sum), .out_ovf(s_out_ovf), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclr = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b1;
        n_in_valid = 1'b0; n_in_prod = '0; n_out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_prod = '0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got in_ready=%b out_valid=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (out_sum !== 16'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got sum=%0d ovf=%b exp 0 0", out_sum, out_ovf);
        end
        rst_n = 1'b1;
        tick();
        $display("reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
    endtask

    task automatic test_full_group();
        out_ready = 1'b1; in_valid = 1'b1; in_prod = 8'd225;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_pre got out_valid=%b in_ready=%b busy=%b exp 0 1 1", out_valid, in_ready, busy);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'd900 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_result got v=%b rdy=%b sum=%0d ovf=%b exp 1 0 900 0", out_valid, in_ready, out_sum, out_ovf);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'd900 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_after got v=%b rdy=%b sum=%0d busy=%b exp 0 1 900 0", out_valid, in_ready, out_sum, busy);
        end
        $display("full_group: sum=%0d ovf=%b", out_sum, out_ovf);
    endtask

    task automatic test_back_pressure();
        logic [7:0] vals [4];
        int bad;
        vals[0] = 8'd10; vals[1] = 8'd20; vals[2] = 8'd30; vals[3] = 8'd40;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_prod = vals[i];
            tick();
        end
        in_prod = 8'd99;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'd100) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d bad cycles (last rdy=%b v=%b sum=%0d) exp 0", bad, in_ready, out_valid, out_sum);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got rdy=%b v=%b exp 1 0", in_ready, out_valid);
        end
        in_valid = 1'b1; in_prod = 8'd1;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd4) begin
            errors++;
            $display("FAIL bp_next_group got v=%b sum=%0d exp 1 4", out_valid, out_sum);
        end
        tick();
        $display("back_pressure: held sum=100, next group sum=4");
    endtask

    task automatic test_overflow();
        n_in_valid = 1'b1; n_in_prod = 8'd225;
        for (int i = 0; i < 4; i++) tick();
        n_in_valid = 1'b0;
        checks++;
        if (n_out_valid !== 1'b1 || n_out_sum !== 9'd388 || n_out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_group got v=%b sum=%0d ovf=%b exp 1 388 1", n_out_valid, n_out_sum, n_out_ovf);
        end
        tick();
        n_in_valid = 1'b1; n_in_prod = 8'd1;
        for (int i = 0; i < 4; i++) tick();
        n_in_valid = 1'b0;
        checks++;
        if (n_out_valid !== 1'b1 || n_out_sum !== 9'd4 || n_out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_next got v=%b sum=%0d ovf=%b exp 1 4 0", n_out_valid, n_out_sum, n_out_ovf);
        end
        tick();
        $display("overflow: narrow sums 388/ovf1 then 4/ovf0");
    endtask

    task automatic test_gapped();
        logic [7:0] vals [4];
        int gaps [4];
        vals[0] = 8'd5; vals[1] = 8'd0; vals[2] = 8'd7; vals[3] = 8'd9;
        gaps[0] = 2; gaps[1] = 3; gaps[2] = 2; gaps[3] = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                checks++;
                if (out_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_pre got v=%b busy=%b exp 0 1", out_valid, busy);
                end
            end
            in_valid = 1'b1; in_prod = vals[i];
            tick();
            in_valid = 1'b0; in_prod = 8'd200;
            for (int g = 0; g < gaps[i]; g++) tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd21) begin
            errors++;
            $display("FAIL gap_result got v=%b sum=%0d exp 1 21", out_valid, out_sum);
        end
        tick();
        $display("gapped: sum=21");
    endtask

    task automatic test_sclr();
        out_ready = 1'b1;
        in_valid = 1'b1; in_prod = 8'd50; tick();
        in_prod = 8'd60; tick();
        sclr = 1'b1; in_prod = 8'd70; tick();
        sclr = 1'b0; in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sclr_clear got busy=%b v=%b rdy=%b exp 0 0 1", busy, out_valid, in_ready);
        end
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_prod = 8'(i); tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd10) begin
            errors++;
            $display("FAIL sclr_group got v=%b sum=%0d exp 1 10", out_valid, out_sum);
        end
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_prod = 8'd3;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        sclr = 1'b1; tick();
        sclr = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'd12) begin
            errors++;
            $display("FAIL sclr_hold got v=%b rdy=%b sum=%0d exp 0 1 12", out_valid, in_ready, out_sum);
        end
        out_ready = 1'b1;
        $display("sclr: group sum=10, hold discarded with sum kept=%0d", out_sum);
    endtask

    task automatic test_reset_mid_group();
        out_ready = 1'b1; in_valid = 1'b1; in_prod = 8'd8;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_sum !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid got v=%b rdy=%b busy=%b sum=%0d exp 0 1 0 0", out_valid, in_ready, busy, out_sum);
        end
        #1 rst_n = 1'b1;
        tick();
        in_valid = 1'b1; in_prod = 8'd8;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd32 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_regroup got v=%b sum=%0d ovf=%b exp 1 32 0", out_valid, out_sum, out_ovf);
        end
        tick();
        $display("reset_mid_group: regroup sum=32");
    endtask

    task automatic test_len1();
        s_in_valid = 1'b1; s_in_prod = 8'd200;
        tick();
        s_in_valid = 1'b0;
        checks++;
        if (s_out_valid !== 1'b1 || s_out_sum !== 16'd200 || s_out_ovf !== 1'b0 || s_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len1_result got v=%b sum=%0d ovf=%b rdy=%b exp 1 200 0 0", s_out_valid, s_out_sum, s_out_ovf, s_in_ready);
        end
        tick();
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL len1_after got v=%b rdy=%b busy=%b exp 0 1 0", s_out_valid, s_in_ready, s_busy);
        end
        $display("len1: sum=200");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_group();
        test_back_pressure();
        test_overflow();
        test_gapped();
        test_sclr();
        test_reset_mid_group();
        test_len1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
